bot_velocity_dispatch: RTL and testbench
========================================

Name: bot_velocity_dispatch

Overview:
- Synthesizable successor to the bot velocity-update writer.
- On an update strobe, snapshots NUM_BOTS (vx, vy) velocity pairs and waits a settle interval.
- Then delivers each pair in ascending bot order over a shared valid/ready bus to per-bot consumers.
- A per-channel watchdog drops unresponsive bots; overruns are counted. Sits between the velocity controller and the bot interface logic.

Parameters:
- NUM_BOTS, 3, number of bot channels (1..16)
- DATA_W, 16, velocity word width; unsigned fixed point, 11 fractional bits at default, passed through unchanged
- VMAX, 2**DATA_W-1, saturation ceiling applied at snapshot
- SETTLE_CYC, 300, idle cycles between snapshot and first delivery; 0 means no settle
- TIMEOUT_CYC, 1024, cycles a channel may withhold ready before it is dropped (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- upd_strobe  in  1  update request; the rising edge is detected internally
- vx_in  in  NUM_BOTS*DATA_W  packed vx; bot i at bits [i*DATA_W +: DATA_W]
- vy_in  in  NUM_BOTS*DATA_W  packed vy, same packing as vx_in
- bot_rdy  in  NUM_BOTS  per-bot ready
- out_valid  out  1  delivery valid
- out_id  out  clog2(NUM_BOTS) (min 1)  target bot index
- out_vx  out  DATA_W  delivered vx
- out_vy  out  DATA_W  delivered vy
- busy  out  1  batch in progress
- done  out  1  one-cycle batch-complete pulse
- timeout_flags  out  NUM_BOTS  sticky per-bot drop flags
- clamp_flags  out  NUM_BOTS  per-bot saturation flags for the last snapshot
- overrun_cnt  out  8  saturating count of ignored strobes

Behaviour:
- Reset (async, rst_n low): all outputs 0, state IDLE, snapshot/pending/counters cleared, strobe history register 0.
  - Strobe high at reset release counts as a rising edge on the first clock.
  - Reset mid-batch abandons the batch; no partial word is held.
- Edge detection: rising edge = upd_strobe high && previous sample low, sampled at clk edge T.
- FSM: IDLE, SETTLE, SCAN, SEND, DONE.
- IDLE: on an edge:
  - Snapshot each vx/vy as min(value, VMAX).
  - clamp_flags[i] = (vx_i > VMAX) || (vy_i > VMAX).
  - pending = all ones, ptr = 0, busy = 1.
  - Go to SETTLE; if SETTLE_CYC = 0, go straight to SCAN.
- SETTLE: stays exactly SETTLE_CYC cycles, then SCAN.
- SCAN: one cycle.
  - Select the lowest pending index >= ptr.
  - If one is found: load out_id, out_vx, out_vy; set out_valid = 1; watchdog = 0; go to SEND.
  - If none is found: go to DONE.
- SEND: out_valid and data are held stable until one of these occurs:
  - Transfer (out_valid && bot_rdy[out_id] at a clk edge): clear pending[id] and timeout_flags[id], out_valid = 0, ptr = id+1, go to SCAN.
  - Timeout (watchdog reaches TIMEOUT_CYC-1 without ready): clear pending[id], set timeout_flags[id], out_valid = 0, ptr = id+1, go to SCAN.
  - Otherwise, increment the watchdog.
- bot_rdy of non-selected bots is ignored.
- DONE: done = 1 for exactly this cycle, then IDLE. busy drops on the DONE->IDLE edge.
- Latency:
  - out_valid first rises after edge T+SETTLE_CYC+1.
  - Each channel costs SCAN(1) + SEND(>=1) cycles.
- Overrun: a rising edge in any state other than IDLE (including DONE) is ignored and increments overrun_cnt, which saturates at 255. The snapshot is not disturbed.
- Inputs are not re-sampled after the snapshot.

Test Plan:
1. NUM_BOTS=3, SETTLE_CYC=4, bot_rdy=3'b111, vx={0x0800,0x1000,0x0000}, strobe edge at T -> transfers at T+6 (id0), T+8 (id1), T+10 (id2) with the matching vx/vy; done high for the cycle after T+11; busy low after T+12.
2. bot_rdy[1] held 0, TIMEOUT_CYC=8 -> id1 held valid for 8 cycles, then dropped; timeout_flags=3'b010; id2 still delivered; done asserted. A later batch with bot 1 ready clears the flag.
3. VMAX=0x7FFF, vx_in for bot 2 = 0x9000 -> out_vx=0x7FFF for id2; clamp_flags=3'b100.
4. Second strobe edge during SEND and another during DONE -> batch unaffected; overrun_cnt=2. 300 ignored edges -> overrun_cnt=255.
5. bot_rdy toggled 0/1 mid-SEND with vx_in changing after the snapshot -> out_vx/out_id stable while waiting; the delivered value equals the snapshot.
6. rst_n pulsed low during SEND of id1 -> all outputs 0 immediately; after release with strobe low, remains IDLE; strobe held high through release -> new batch starts on the first clock.

Source files
------------

// File: rtl/bot_velocity_dispatch.sv
// bot_velocity_dispatch
//   Snapshots NUM_BOTS (vx, vy) velocity pairs on a rising edge of upd_strobe,
//   waits SETTLE_CYC cycles, then delivers each pair in ascending bot order
//   over a shared valid/ready bus. A per-channel watchdog drops a bot that
//   withholds ready for TIMEOUT_CYC cycles. Strobe edges arriving while a
//   batch is in flight are ignored and counted.
//
// Ports
//   clk, rst_n         system clock, async active-low reset
//   upd_strobe         update request (rising edge detected internally)
//   vx_in, vy_in       packed velocities, bot i at [i*DATA_W +: DATA_W]
//   bot_rdy            per-bot ready; only the selected bot's bit matters
//   out_valid, out_id,
//   out_vx, out_vy     delivery bus
//   busy, done         batch in progress / one-cycle completion pulse
//   timeout_flags      sticky per-bot drop flags (cleared by a good transfer)
//   clamp_flags        per-bot saturation flags of the last snapshot
//   overrun_cnt        saturating count of ignored strobe edges
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for a strobe edge
// S_SETTLE | snapshot taken, counting down the settle interval
// S_SCAN   | pick the lowest pending bot at or above ptr, or finish
// S_SEND   | out_valid held until ready or watchdog expiry
// S_DONE   | one-cycle done pulse
module bot_velocity_dispatch #(
  parameter int                NUM_BOTS    = 3,
  parameter int                DATA_W      = 16,
  parameter logic [DATA_W-1:0] VMAX        = {DATA_W{1'b1}},
  parameter int                SETTLE_CYC  = 300,
  parameter int                TIMEOUT_CYC = 1024,
  localparam int               ID_W        = (NUM_BOTS > 1) ? $clog2(NUM_BOTS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     upd_strobe,
  input  logic [NUM_BOTS*DATA_W-1:0] vx_in,
  input  logic [NUM_BOTS*DATA_W-1:0] vy_in,
  input  logic [NUM_BOTS-1:0]      bot_rdy,
  output logic                     out_valid,
  output logic [ID_W-1:0]          out_id,
  output logic [DATA_W-1:0]        out_vx,
  output logic [DATA_W-1:0]        out_vy,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_BOTS-1:0]      timeout_flags,
  output logic [NUM_BOTS-1:0]      clamp_flags,
  output logic [7:0]               overrun_cnt
);

  localparam int PTR_W = $clog2(NUM_BOTS + 1);
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_SCAN, S_SEND, S_DONE} state_t;

  state_t state, state_nxt;

  logic                strobe_q;
  logic                strobe_rise;
  logic [NUM_BOTS-1:0] pending;
  logic [PTR_W-1:0]    ptr;
  logic [SET_W-1:0]    settle_cnt;
  logic [WD_W-1:0]     wd_cnt;
  logic [DATA_W-1:0]   snap_vx [NUM_BOTS];
  logic [DATA_W-1:0]   snap_vy [NUM_BOTS];

  logic [DATA_W-1:0]   sat_vx [NUM_BOTS];
  logic [DATA_W-1:0]   sat_vy [NUM_BOTS];
  logic [NUM_BOTS-1:0] sat_hit;

  logic                sel_found;
  logic [ID_W-1:0]     sel_idx;
  logic [DATA_W-1:0]   sel_vx;
  logic [DATA_W-1:0]   sel_vy;
  logic                rdy_sel;
  logic                xfer;
  logic                wd_expire;

  assign strobe_rise = upd_strobe & ~strobe_q;

  assign out_valid = (state == S_SEND);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // Saturation applied to the live inputs; only latched in IDLE on an edge.
  always_comb begin
    sat_hit = '0;
    for (int i = 0; i < NUM_BOTS; i++) begin
      sat_vx[i]  = (vx_in[i*DATA_W +: DATA_W] > VMAX) ? VMAX : vx_in[i*DATA_W +: DATA_W];
      sat_vy[i]  = (vy_in[i*DATA_W +: DATA_W] > VMAX) ? VMAX : vy_in[i*DATA_W +: DATA_W];
      sat_hit[i] = (vx_in[i*DATA_W +: DATA_W] > VMAX) || (vy_in[i*DATA_W +: DATA_W] > VMAX);
    end
  end

  // Lowest pending index at or above ptr: scan downward so the last hit wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_vx    = '0;
    sel_vy    = '0;
    for (int i = NUM_BOTS - 1; i >= 0; i--) begin
      if (pending[i] && (i >= int'(ptr))) begin
        sel_found = 1'b1;
        sel_idx   = ID_W'(i);
        sel_vx    = snap_vx[i];
        sel_vy    = snap_vy[i];
      end
    end
  end

  always_comb begin
    rdy_sel = 1'b0;
    for (int i = 0; i < NUM_BOTS; i++) begin
      if (out_id == ID_W'(i)) rdy_sel = bot_rdy[i];
    end
  end

  assign xfer      = (state == S_SEND) && rdy_sel;
  assign wd_expire = (state == S_SEND) && !rdy_sel && (wd_cnt == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (strobe_rise) state_nxt = (SETTLE_CYC == 0) ? S_SCAN : S_SETTLE;
      S_SETTLE: if (settle_cnt == '0) state_nxt = S_SCAN;
      S_SCAN:   state_nxt = sel_found ? S_SEND : S_DONE;
      S_SEND:   if (xfer || wd_expire) state_nxt = S_SCAN;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q      <= 1'b0;
      pending       <= '0;
      ptr           <= '0;
      settle_cnt    <= '0;
      wd_cnt        <= '0;
      out_id        <= '0;
      out_vx        <= '0;
      out_vy        <= '0;
      timeout_flags <= '0;
      clamp_flags   <= '0;
      overrun_cnt   <= '0;
      for (int i = 0; i < NUM_BOTS; i++) begin
        snap_vx[i] <= '0;
        snap_vy[i] <= '0;
      end
    end else begin
      strobe_q <= upd_strobe;

      if (strobe_rise && (state != S_IDLE) && (overrun_cnt != 8'hFF)) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end

      case (state)
        S_IDLE: begin
          if (strobe_rise) begin
            for (int i = 0; i < NUM_BOTS; i++) begin
              snap_vx[i] <= sat_vx[i];
              snap_vy[i] <= sat_vy[i];
            end
            clamp_flags <= sat_hit;
            pending     <= '1;
            ptr         <= '0;
            // Terminal count at zero gives exactly SETTLE_CYC cycles in SETTLE.
            settle_cnt  <= SET_W'(SETTLE_CYC - 1);
          end
        end
        S_SETTLE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - SET_W'(1);
        end
        S_SCAN: begin
          if (sel_found) begin
            out_id <= sel_idx;
            out_vx <= sel_vx;
            out_vy <= sel_vy;
            wd_cnt <= WD_W'(TIMEOUT_CYC - 1);
          end
        end
        S_SEND: begin
          if (xfer || wd_expire) begin
            for (int i = 0; i < NUM_BOTS; i++) begin
              if (out_id == ID_W'(i)) begin
                pending[i]       <= 1'b0;
                timeout_flags[i] <= wd_expire;
              end
            end
            ptr <= PTR_W'(out_id) + PTR_W'(1);
          end else begin
            wd_cnt <= wd_cnt - WD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bot_velocity_dispatch.sv
module tb_bot_velocity_dispatch;

  localparam int          NB  = 3;
  localparam int          DW  = 16;
  localparam int          SET = 4;
  localparam int          TO  = 8;
  localparam logic [15:0] VM  = 16'h7FFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          upd_strobe = 1'b0;
  logic [47:0]   vx_in = '0;
  logic [47:0]   vy_in = '0;
  logic [2:0]    bot_rdy = '0;
  logic          out_valid;
  logic [1:0]    out_id;
  logic [15:0]   out_vx;
  logic [15:0]   out_vy;
  logic          busy;
  logic          done;
  logic [2:0]    timeout_flags;
  logic [2:0]    clamp_flags;
  logic [7:0]    overrun_cnt;

  bot_velocity_dispatch #(
    .NUM_BOTS(NB), .DATA_W(DW), .VMAX(VM), .SETTLE_CYC(SET), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .upd_strobe(upd_strobe),
    .vx_in(vx_in), .vy_in(vy_in), .bot_rdy(bot_rdy),
    .out_valid(out_valid), .out_id(out_id), .out_vx(out_vx), .out_vy(out_vy),
    .busy(busy), .done(done), .timeout_flags(timeout_flags),
    .clamp_flags(clamp_flags), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] vx;
    logic [15:0] vy;
    bit          to;
  } exp_t;

  exp_t exp_q[$];
  int   xfer_t[$];
  bit   sb_en = 1'b1;
  int   t_edge;
  int   done_cyc;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sat(logic [15:0] v);
    return (v > VM) ? VM : v;
  endfunction

  task automatic push_batch(logic [2:0] plan);
    exp_t e;
    for (int i = 0; i < NB; i++) begin
      e.id = 2'(i);
      e.vx = sat(vx_in[i*DW +: DW]);
      e.vy = sat(vy_in[i*DW +: DW]);
      e.to = !plan[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(logic [2:0] plan);
    @(posedge clk); #1;
    xfer_t.delete();
    push_batch(plan);
    upd_strobe = 1'b1;
    @(posedge clk); #1;
    t_edge     = cyc;
    upd_strobe = 1'b0;
  endtask

  task automatic wait_done(string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    chk({tag, "_done"}, done, 1);
    done_cyc = cyc;
    chk({tag, "_busy_at_done"}, busy, 1);
    @(negedge clk);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_sb_left"}, exp_q.size(), 0);
  endtask

  task automatic check_times(string tag);
    chk({tag, "_nxfer"}, xfer_t.size(), 3);
    if (xfer_t.size() == 3) begin
      chk({tag, "_t0"}, xfer_t[0], t_edge + 6);
      chk({tag, "_t1"}, xfer_t[1], t_edge + 8);
      chk({tag, "_t2"}, xfer_t[2], t_edge + 10);
    end
  endtask

  // Monitor: checks hold stability, pops the scoreboard on each transfer or drop.
  bit          pv = 1'b0;
  bit          drop_exp = 1'b0;
  int          run = 0;
  logic [1:0]  pid;
  logic [15:0] pvx, pvy;
  exp_t        me;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0; run = 0; drop_exp = 1'b0;
    end else begin
      if (drop_exp) chk("valid_drop", out_valid, 0);
      drop_exp = 1'b0;
      if (out_valid) begin
        if (pv) begin
          chk("hold_id", out_id, pid);
          chk("hold_vx", out_vx, pvx);
          chk("hold_vy", out_vy, pvy);
        end
        run = pv ? run + 1 : 1;
        if (bot_rdy[out_id] === 1'b1 || run >= TO) begin
          if (sb_en) begin
            chk("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              me = exp_q.pop_front();
              chk("xfer_id", out_id, me.id);
              chk("xfer_vx", out_vx, me.vx);
              chk("xfer_vy", out_vy, me.vy);
              chk("outcome_to", bot_rdy[out_id] !== 1'b1, me.to);
            end
          end
          xfer_t.push_back(cyc + 1);
          pv = 1'b0;
          drop_exp = 1'b1;
        end else begin
          pv = 1'b1; pid = out_id; pvx = out_vx; pvy = out_vy;
        end
      end else begin
        pv = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;

    // Reset state
    #22;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_id", out_id, 0);
    chk("rst_vx", out_vx, 0);
    chk("rst_ovr", overrun_cnt, 0);
    chk("rst_flags", {timeout_flags, clamp_flags}, 0);
    @(negedge clk) rst_n = 1'b1;

    // 1: basic ordered delivery and latency
    bot_rdy = 3'b111;
    vx_in = {16'h0000, 16'h1000, 16'h0800};
    vy_in = {16'h0300, 16'h0200, 16'h0100};
    pulse(3'b111);
    chk("t1_busy", busy, 1);
    chk("t1_clamp", clamp_flags, 3'b000);
    wait_done("t1");
    check_times("t1");
    chk("t1_done_cyc", done_cyc, t_edge + 11);

    // 3: saturation, 0x7FFF sits exactly at the ceiling
    vx_in = {16'h9000, 16'h0123, 16'h7FFF};
    vy_in = {16'h0001, 16'h7FFF, 16'h0456};
    pulse(3'b111);
    chk("t3_clamp", clamp_flags, 3'b100);
    wait_done("t3");

    // 2: bot 1 withholds ready, then a later batch clears its flag
    bot_rdy = 3'b101;
    vx_in = {16'h0aaa, 16'h0bbb, 16'h0ccc};
    vy_in = {16'h0111, 16'h0222, 16'h0333};
    pulse(3'b101);
    wait_done("t2");
    chk("t2_tflags", timeout_flags, 3'b010);
    bot_rdy = 3'b111;
    pulse(3'b111);
    chk("t2_sticky", timeout_flags, 3'b010);
    wait_done("t2b");
    chk("t2_cleared", timeout_flags, 3'b000);

    // 5: inputs change after snapshot; other bots' ready toggles while waiting
    bot_rdy = 3'b000;
    vx_in = {16'h0321, 16'h0654, 16'h0987};
    vy_in = {16'h0abc, 16'h0def, 16'h0135};
    pulse(3'b111);
    vx_in = ~vx_in;
    vy_in = 48'h1234_5678_4321;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 50);
    chk("t5_valid", out_valid, 1);
    @(posedge clk); #1 bot_rdy = 3'b110;
    @(posedge clk); #1 bot_rdy = 3'b000;
    @(posedge clk); #1 bot_rdy = 3'b110;
    @(posedge clk); #1 bot_rdy = 3'b111;
    wait_done("t5");

    // 4: edges during SEND and DONE are ignored
    vx_in = {16'h0700, 16'h0600, 16'h0500};
    vy_in = {16'h0070, 16'h0060, 16'h0050};
    pulse(3'b111);
    tick(5);
    upd_strobe = 1'b1;
    tick(1);
    upd_strobe = 1'b0;
    chk("t4_ovr1", overrun_cnt, 1);
    tick(5);
    chk("t4_done", done, 1);
    upd_strobe = 1'b1;
    tick(1);
    upd_strobe = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_ovr2", overrun_cnt, 2);
    chk("t4_sb_left", exp_q.size(), 0);
    check_times("t4");

    // 4b: flood of edges saturates the counter
    sb_en = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      upd_strobe = ~upd_strobe;
      tick(1);
    end
    upd_strobe = 1'b0;
    tick(30);
    exp_q.delete();
    sb_en = 1'b1;
    chk("t4_sat", overrun_cnt, 255);
    chk("t4_idle", busy, 0);

    // 6: reset during SEND of id1
    bot_rdy = 3'b101;
    vx_in = {16'h0111, 16'h0222, 16'h0333};
    vy_in = {16'h0444, 16'h0555, 16'h0666};
    pulse(3'b101);
    n = 0;
    do begin @(negedge clk); n++; end while (!(out_valid && out_id == 2'd1) && n < 50);
    chk("t6_at_id1", out_valid && out_id == 2'd1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_data", {out_id, out_vx, out_vy}, 0);
    chk("t6_flags", {timeout_flags, clamp_flags}, 0);
    chk("t6_ovr", overrun_cnt, 0);
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("t6_stay_idle", busy, 0);
    chk("t6_no_valid", out_valid, 0);
    rst_n = 1'b0;
    bot_rdy = 3'b111;
    upd_strobe = 1'b1;
    xfer_t.delete();
    push_batch(3'b111);
    tick(1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    t_edge = cyc;
    chk("t6_restart", busy, 1);
    upd_strobe = 1'b0;
    wait_done("t6");
    check_times("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
